// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: IDLE/RUN/HALT control, programmable jump-target table,
// absolute/conditional/PC-relative branching and a saturating retired-instruction counter.
module fetch_unit #(
  parameter int unsigned D         = 12,
  parameter int unsigned LW        = 4,
  parameter int unsigned HALT_ADDR = 500,
  parameter int unsigned CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic [1:0]    branch,
  input  logic [LW-1:0] lut_idx,
  input  logic          cnd_i,
  input  logic          cnd_en,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e        state_q;
  logic          cnd_q;
  logic [D-1:0]  lut_q [2**LW];
  logic [D-1:0]  target;
  logic [D-1:0]  pc_inc;
  logic [D-1:0]  pc_d;
  logic          at_halt;

  assign target  = lut_q[lut_idx];
  assign pc_inc  = prog_ctr + D'(1);
  assign at_halt = (prog_ctr == D'(HALT_ADDR));

  // Conditional branches use the flag registered before this edge (one-cycle hazard).
  always_comb begin
    pc_d = pc_inc;
    unique case (branch)
      2'b00: pc_d = pc_inc;
      2'b01: pc_d = target;
      2'b10: pc_d = cnd_q ? target : pc_inc;
      2'b11: pc_d = cnd_q ? (prog_ctr + target) : pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      prog_ctr    <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      instr_count <= '0;
      cnd_q       <= 1'b0;
      for (int i = 0; i < 2**LW; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
          end
          if (start) begin
            state_q <= StRun;
            running <= 1'b1;
          end
        end
        StRun: begin
          if (!stall) begin
            if (at_halt) begin
              // The instruction at the halt address never retires.
              state_q <= StHalt;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              prog_ctr <= pc_d;
              if (instr_count != '1) begin
                instr_count <= instr_count + CW'(1);
              end
              if (cnd_en) begin
                cnd_q <= cnd_i;
              end
            end
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: default, narrow-PC and narrow-counter instances.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, cnd_i, cnd_en, lut_we;
  logic [1:0]  branch;

  // Default instance (D=12, LW=4, HALT_ADDR=500, CW=16)
  logic [3:0]  m_idx, m_waddr;
  logic [11:0] m_wdata;
  logic [11:0] m_pc;
  logic        m_run, m_done;
  logic [15:0] m_cnt;

  // Narrow PC instance (D=3, LW=2, HALT_ADDR=6)
  logic [1:0]  s_idx, s_waddr;
  logic [2:0]  s_wdata;
  logic [2:0]  s_pc;
  logic        s_run, s_done;
  logic [15:0] s_cnt;

  // Narrow counter instance (D=8, LW=2, HALT_ADDR=20, CW=4)
  logic [7:0]  t_pc;
  logic        t_run, t_done;
  logic [3:0]  t_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit u_main (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .branch(branch),
    .lut_idx(m_idx), .cnd_i(cnd_i), .cnd_en(cnd_en), .lut_we(lut_we),
    .lut_waddr(m_waddr), .lut_wdata(m_wdata), .prog_ctr(m_pc), .running(m_run),
    .done(m_done), .instr_count(m_cnt)
  );

  fetch_unit #(.D(3), .LW(2), .HALT_ADDR(6), .CW(16)) u_small (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .branch(branch),
    .lut_idx(s_idx), .cnd_i(cnd_i), .cnd_en(cnd_en), .lut_we(lut_we),
    .lut_waddr(s_waddr), .lut_wdata(s_wdata), .prog_ctr(s_pc), .running(s_run),
    .done(s_done), .instr_count(s_cnt)
  );

  fetch_unit #(.D(8), .LW(2), .HALT_ADDR(20), .CW(4)) u_sat (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .branch(2'b00),
    .lut_idx(2'b00), .cnd_i(1'b0), .cnd_en(1'b0), .lut_we(1'b0),
    .lut_waddr(2'b00), .lut_wdata(8'h00), .prog_ctr(t_pc), .running(t_run),
    .done(t_done), .instr_count(t_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read there too.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic m_write(input logic [3:0] idx, input logic [11:0] data);
    lut_we  = 1'b1;
    m_waddr = idx;
    m_wdata = data;
    step();
    lut_we  = 1'b0;
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; stall = 1'b0; cnd_i = 1'b0; cnd_en = 1'b0;
    lut_we = 1'b0; branch = 2'b00;
    m_idx = '0; m_waddr = '0; m_wdata = '0;
    s_idx = '0; s_waddr = '0; s_wdata = '0;
    step();
    do_reset();
    check_eq("rst_pc", m_pc, 0);
    check_eq("rst_running", m_run, 0);
    check_eq("rst_done", m_done, 0);
    check_eq("rst_count", m_cnt, 0);

    // Straight-line fetch to the halt address
    do_start();
    check_eq("start_running", m_run, 1);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (m_pc != 12'(i)) bad++;
      step();
    end
    check_eq("straight_seq_errs", bad, 0);
    check_eq("at_halt_pc", m_pc, 500);
    check_eq("at_halt_done", m_done, 0);
    check_eq("at_halt_count", m_cnt, 500);
    step();
    check_eq("halt_done", m_done, 1);
    check_eq("halt_running", m_run, 0);
    check_eq("halt_pc", m_pc, 500);
    check_eq("halt_count", m_cnt, 500);
    do_start();
    step();
    check_eq("halt_start_done", m_done, 1);
    check_eq("halt_start_running", m_run, 0);
    check_eq("halt_start_pc", m_pc, 500);

    // Table programming and branching
    do_reset();
    m_write(4'd3, 12'd40);
    m_write(4'd1, 12'hFFC);
    m_write(4'd2, 12'd10);
    do_start();
    repeat (5) step();
    check_eq("pre_jump_pc", m_pc, 5);
    branch = 2'b01; m_idx = 4'd3;
    step();
    branch = 2'b00;
    check_eq("abs_jump_pc", m_pc, 40);
    check_eq("abs_jump_count", m_cnt, 6);
    lut_we = 1'b1; m_waddr = 4'd3; m_wdata = 12'd99;
    step();
    lut_we = 1'b0;
    check_eq("run_write_pc", m_pc, 41);
    branch = 2'b01; m_idx = 4'd3;
    step();
    check_eq("lut_unchanged_pc", m_pc, 40);

    // Flag hazard: same-cycle capture is not seen by the branch
    branch = 2'b10; cnd_en = 1'b1; cnd_i = 1'b1;
    step();
    check_eq("hazard_not_taken", m_pc, 41);
    cnd_en = 1'b0; cnd_i = 1'b0;
    step();
    check_eq("hazard_taken", m_pc, 40);

    // Relative branch backwards by 4
    branch = 2'b01; m_idx = 4'd2;
    step();
    check_eq("to_ten_pc", m_pc, 10);
    branch = 2'b11; m_idx = 4'd1;
    step();
    check_eq("rel_back_pc", m_pc, 6);
    branch = 2'b00; cnd_en = 1'b1; cnd_i = 1'b0;
    step();
    cnd_en = 1'b0;
    branch = 2'b11;
    step();
    check_eq("rel_not_taken_pc", m_pc, 8);
    check_eq("pre_stall_count", m_cnt, 14);

    // Stall holds PC, flag and count
    stall = 1'b1; branch = 2'b01; m_idx = 4'd3; cnd_en = 1'b1; cnd_i = 1'b1;
    bad = 0;
    repeat (3) begin
      step();
      if (m_pc != 12'd8 || m_cnt != 16'd14) bad++;
    end
    check_eq("stall_hold_errs", bad, 0);
    stall = 1'b0; cnd_en = 1'b0; cnd_i = 1'b0; branch = 2'b10;
    step();
    check_eq("stall_flag_held", m_pc, 9);
    check_eq("post_stall_count", m_cnt, 15);
    branch = 2'b00;

    // Mid-run reset clears outputs and table
    do_reset();
    check_eq("midrst_pc", m_pc, 0);
    check_eq("midrst_done", m_done, 0);
    check_eq("midrst_running", m_run, 0);
    check_eq("midrst_count", m_cnt, 0);
    do_start();
    branch = 2'b01; m_idx = 4'd3;
    step();
    branch = 2'b00;
    check_eq("midrst_lut_cleared", m_pc, 0);

    // Stall at the halt address delays done
    do_reset();
    m_write(4'd4, 12'd499);
    do_start();
    branch = 2'b01; m_idx = 4'd4;
    step();
    branch = 2'b00;
    check_eq("jump_499", m_pc, 499);
    step();
    check_eq("reach_500", m_pc, 500);
    stall = 1'b1;
    repeat (2) step();
    check_eq("stalled_halt_done", m_done, 0);
    check_eq("stalled_halt_running", m_run, 1);
    stall = 1'b0;
    step();
    check_eq("unstalled_done", m_done, 1);
    check_eq("unstalled_running", m_run, 0);
    check_eq("unstalled_pc", m_pc, 500);
    check_eq("unstalled_count", m_cnt, 2);

    // Narrow PC: relative wrap and not-taken case
    do_reset();
    lut_we = 1'b1; s_waddr = 2'd1; s_wdata = 3'd5;
    step();
    lut_we = 1'b0;
    do_start();
    cnd_en = 1'b1; cnd_i = 1'b1;
    step();
    cnd_en = 1'b0; cnd_i = 1'b0;
    step();
    check_eq("small_pc2", s_pc, 2);
    branch = 2'b11; s_idx = 2'd1;
    step();
    branch = 2'b00;
    check_eq("small_rel_wrap", s_pc, 7);
    step();
    check_eq("small_inc_wrap", s_pc, 0);
    cnd_en = 1'b1; cnd_i = 1'b0;
    step();
    cnd_en = 1'b0;
    branch = 2'b11;
    step();
    branch = 2'b00;
    check_eq("small_rel_not_taken", s_pc, 2);

    // Narrow counter saturates at 15 over 20 retirements
    do_reset();
    do_start();
    bad = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (t_done) begin
        bad = 0;
        break;
      end
    end
    check_eq("sat_done_in_budget", bad, 0);
    check_eq("sat_count", t_cnt, 15);
    check_eq("sat_pc", t_pc, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
